idct_block_scheduler: RTL and testbench

- Top-level sequencer for the decompressor's block pipeline.
- Walks every block of the Y, U and V planes in order. For each block it runs the fetch/IDCT stage, which fills the S RAM, then the write-back stage (WriteS), which drains the S RAM to external SRAM.
- Drives the shared block coordinates (Rb, Cb) and the plane flags (Y_finished, U_finished) consumed by both stages.
- Arbitrates the single external SRAM port between the two stages.

---
 rtl/idct_block_scheduler.sv | 102 ++++++++++
 tb/tb_idct_block_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/idct_block_scheduler.sv
// idct_block_scheduler: walks every Y/U/V block, sequencing fetch/IDCT then write-back and muxing the shared SRAM port
module idct_block_scheduler #(
   parameter int Y_ROW_BLOCKS  = 9,
   parameter int Y_COL_BLOCKS  = 12,
   parameter int UV_ROW_BLOCKS = 18,
   parameter int UV_COL_BLOCKS = 12
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        start,
   output logic        fetch_start,
   input  logic        fetch_done,
   output logic        write_start,
   input  logic        write_done,
   output logic [4:0]  Rb,
   output logic [4:0]  Cb,
   output logic        Y_finished,
   output logic        U_finished,
   input  logic [17:0] fetch_SRAM_address,
   input  logic        fetch_SRAM_we_n,
   input  logic [15:0] fetch_SRAM_write_data,
   input  logic [17:0] write_SRAM_address,
   input  logic        write_SRAM_we_n,
   input  logic [15:0] write_SRAM_write_data,
   output logic [17:0] SRAM_address,
   output logic        SRAM_we_n,
   output logic [15:0] SRAM_write_data,
   output logic [9:0]  block_count,
   output logic        busy,
   output logic        done
);
   typedef enum logic [2:0] {IDLE, FETCH_START, FETCH_WAIT, WRITE_START, WRITE_WAIT, ADVANCE, DONE_ST} state_t;
   state_t state, state_n;
   logic [4:0] rb_n, cb_n, col_lim, row_lim;
   logic [9:0] cnt_n;
   logic yf_n, uf_n, last_col, last_row, f_own, w_own;
   assign col_lim  = Y_finished ? 5'(UV_COL_BLOCKS) : 5'(Y_COL_BLOCKS);
   assign row_lim  = Y_finished ? 5'(UV_ROW_BLOCKS) : 5'(Y_ROW_BLOCKS);
   assign last_col = Cb == col_lim - 5'd1;
   assign last_row = Rb == row_lim - 5'd1;
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         Rb          <= '0;
         Cb          <= '0;
         Y_finished  <= 1'b0;
         U_finished  <= 1'b0;
         block_count <= '0;
      end else begin
         state       <= state_n;
         Rb          <= rb_n;
         Cb          <= cb_n;
         Y_finished  <= yf_n;
         U_finished  <= uf_n;
         block_count <= cnt_n;
      end
   end
   always_comb begin
      state_n = state;
      rb_n    = Rb;
      cb_n    = Cb;
      yf_n    = Y_finished;
      uf_n    = U_finished;
      cnt_n   = block_count;
      unique case (state)
         IDLE: begin
            state_n = start ? FETCH_START : IDLE;
            cnt_n   = start ? '0 : block_count;
         end
         FETCH_START: state_n = FETCH_WAIT;
         FETCH_WAIT:  state_n = fetch_done ? WRITE_START : FETCH_WAIT;
         WRITE_START: state_n = WRITE_WAIT;
         WRITE_WAIT:  state_n = write_done ? ADVANCE : WRITE_WAIT;
         ADVANCE: begin
            cnt_n   = block_count + 10'd1;
            cb_n    = last_col ? '0 : Cb + 5'd1;
            rb_n    = !last_col ? Rb : last_row ? '0 : Rb + 5'd1;
            // Y end sets Y_finished, U end sets U_finished, V end finishes the frame
            yf_n    = Y_finished | (last_col & last_row);
            uf_n    = U_finished | (last_col & last_row & Y_finished);
            state_n = (last_col && last_row && U_finished) ? DONE_ST : FETCH_START;
         end
         DONE_ST: begin
            state_n = IDLE;
            rb_n    = '0;
            cb_n    = '0;
            yf_n    = 1'b0;
            uf_n    = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end
   assign fetch_start     = state == FETCH_START;
   assign write_start     = state == WRITE_START;
   assign done            = state == DONE_ST;
   assign busy            = state != IDLE;
   assign f_own           = state == FETCH_START || state == FETCH_WAIT;
   assign w_own           = state == WRITE_START || state == WRITE_WAIT;
   assign SRAM_address    = f_own ? fetch_SRAM_address : w_own ? write_SRAM_address : '0;
   assign SRAM_we_n       = f_own ? fetch_SRAM_we_n : w_own ? write_SRAM_we_n : 1'b1;
   assign SRAM_write_data = f_own ? fetch_SRAM_write_data : w_own ? write_SRAM_write_data : '0;
endmodule

// File: tb/tb_idct_block_scheduler.sv
// tb_idct_block_scheduler: directed bench for the block scheduler
module tb_idct_block_scheduler;
   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic        fetch_done = 1'b0;
   logic        write_done = 1'b0;
   logic        fetch_start, write_start, Y_finished, U_finished, SRAM_we_n, busy, done;
   logic [4:0]  Rb, Cb;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic [9:0]  block_count;
   logic [17:0] fetch_SRAM_address = 18'h00123;
   logic        fetch_SRAM_we_n = 1'b0;
   logic [15:0] fetch_SRAM_write_data = 16'hA5A5;
   logic [17:0] write_SRAM_address = 18'h3FFFF;
   logic        write_SRAM_we_n = 1'b1;
   logic [15:0] write_SRAM_write_data = 16'h5A5A;
   int checks = 0;
   int failures = 0;
   int fs_cnt = 0;
   int done_cnt = 0;
   idct_block_scheduler dut (
      .Clock(Clock), .Reset(Reset), .start(start),
      .fetch_start(fetch_start), .fetch_done(fetch_done),
      .write_start(write_start), .write_done(write_done),
      .Rb(Rb), .Cb(Cb), .Y_finished(Y_finished), .U_finished(U_finished),
      .fetch_SRAM_address(fetch_SRAM_address), .fetch_SRAM_we_n(fetch_SRAM_we_n),
      .fetch_SRAM_write_data(fetch_SRAM_write_data),
      .write_SRAM_address(write_SRAM_address), .write_SRAM_we_n(write_SRAM_we_n),
      .write_SRAM_write_data(write_SRAM_write_data),
      .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_write_data(SRAM_write_data),
      .block_count(block_count), .busy(busy), .done(done)
   );
   always #5 Clock = ~Clock;
   always @(posedge Clock) begin
      if (fetch_start === 1'b1) fs_cnt <= fs_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask
   task automatic exp_coord(input int idx, output int rb, output int cb, output int yf, output int uf);
      int j;
      j  = idx < 108 ? idx : idx < 324 ? idx - 108 : idx - 324;
      rb = j / 12;
      cb = j % 12;
      yf = idx >= 108 ? 1 : 0;
      uf = idx >= 324 ? 1 : 0;
   endtask
   task automatic wait_fetch_start(input int idx);
      int rb, cb, yf, uf;
      for (int k = 0; k < 10 && fetch_start !== 1'b1; k++) tick();
      check("fetch_start", 32'(fetch_start), 1);
      exp_coord(idx, rb, cb, yf, uf);
      check($sformatf("Rb[%0d]", idx), 32'(Rb), 32'(rb));
      check($sformatf("Cb[%0d]", idx), 32'(Cb), 32'(cb));
      check($sformatf("Yfin[%0d]", idx), 32'(Y_finished), 32'(yf));
      check($sformatf("Ufin[%0d]", idx), 32'(U_finished), 32'(uf));
   endtask
   task automatic run_block(input int idx);
      wait_fetch_start(idx);
      tick();
      if (idx < 2) begin
         check("fw_addr", 32'(SRAM_address), 32'h00123);
         check("fw_we_n", 32'(SRAM_we_n), 0);
         check("fw_data", 32'(SRAM_write_data), 32'hA5A5);
      end
      fetch_done = 1'b1;
      tick();
      fetch_done = 1'b0;
      check("write_start", 32'(write_start), 1);
      tick();
      if (idx < 2) begin
         check("ww_addr", 32'(SRAM_address), 32'h3FFFF);
         check("ww_we_n", 32'(SRAM_we_n), 1);
         check("ww_data", 32'(SRAM_write_data), 32'h5A5A);
      end
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      if (idx < 2) begin
         check("adv_we_n", 32'(SRAM_we_n), 1);
         check("adv_addr", 32'(SRAM_address), 0);
      end
      tick();
   endtask
   initial begin
      int fs0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_Rb", 32'(Rb), 0);
      check("rst_Cb", 32'(Cb), 0);
      check("rst_flags", {30'd0, Y_finished, U_finished}, 0);
      check("rst_count", 32'(block_count), 0);
      check("rst_we_n", 32'(SRAM_we_n), 1);
      check("rst_addr", 32'(SRAM_address), 0);
      check("rst_pulses", {29'd0, fetch_start, write_start, done}, 0);
      Reset = 1'b0;
      tick();
      check("idle_we_n", 32'(SRAM_we_n), 1);
      fs0   = fs_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 540; i++) run_block(i);
      check("done_pulse", 32'(done), 1);
      check("done_count", 32'(block_count), 540);
      tick();
      check("post_done", 32'(done), 0);
      check("post_busy", 32'(busy), 0);
      check("post_RbCb", {22'd0, Rb, Cb}, 0);
      check("post_flags", {30'd0, Y_finished, U_finished}, 0);
      check("post_count", 32'(block_count), 540);
      check("fs_total", 32'(fs_cnt - fs0), 540);
      check("done_total", 32'(done_cnt), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_count", 32'(block_count), 0);
      run_block(0);
      wait_fetch_start(1);
      tick();
      write_done = 1'b1;
      start      = 1'b1;
      tick();
      write_done = 1'b0;
      start      = 1'b0;
      check("spur_wstart", 32'(write_start), 0);
      check("spur_addr", 32'(SRAM_address), 32'h00123);
      check("spur_count", 32'(block_count), 1);
      for (int k = 0; k < 6; k++) tick();
      check("stall_Cb", 32'(Cb), 1);
      check("stall_busy", 32'(busy), 1);
      check("stall_addr", 32'(SRAM_address), 32'h00123);
      fetch_done = 1'b1;
      tick();
      fetch_done = 1'b0;
      check("wstart_after", 32'(write_start), 1);
      tick();
      fetch_done = 1'b1;
      write_done = 1'b1;
      tick();
      fetch_done = 1'b0;
      write_done = 1'b0;
      check("both_adv_we_n", 32'(SRAM_we_n), 1);
      tick();
      check("both_count", 32'(block_count), 2);
      check("both_Cb", 32'(Cb), 2);
      for (int i = 2; i < 200; i++) run_block(i);
      wait_fetch_start(200);
      tick();
      fetch_done = 1'b1;
      tick();
      fetch_done = 1'b0;
      tick();
      check("b200_ww_addr", 32'(SRAM_address), 32'h3FFFF);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_RbCb", {22'd0, Rb, Cb}, 0);
      check("mid_rst_flags", {30'd0, Y_finished, U_finished}, 0);
      check("mid_rst_we_n", 32'(SRAM_we_n), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      run_block(0);
      wait_fetch_start(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
